// File: rtl/rtype_mc_datapath.sv
// Multi-cycle R-type datapath: IDLE -> DECODE -> EXEC -> WB, with register file and debug read port.
// Define OVF_TRAP_EN to report signed add/sub overflow on ovf and suppress the overflowing write.
module rtype_mc_datapath #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] out,
    output logic [5:0]        op,
    output logic              zero,
    output logic              done,
    output logic              illegal,
    output logic              ovf,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int IW  = $clog2(NREGS);
    localparam int SHW = $clog2(DATA_W);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t            state_q, state_d;
    logic [31:0]       instr_q;
    logic [5:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q, out_q;
    logic              zero_q, illegal_q, ovf_q;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic [IW-1:0]     rs_idx, rt_idx, rd_idx;
    logic [5:0]        funct;
    logic [SHW-1:0]    shamt_m;
    logic [DATA_W-1:0] sum, diff, alu_res;
    logic              alu_ill, ovf_d, reg_we;

    assign rs_idx  = instr_q[21 +: IW];
    assign rt_idx  = instr_q[16 +: IW];
    assign rd_idx  = instr_q[11 +: IW];
    assign funct   = instr_q[5:0];
    assign shamt_m = SHW'(instr_q[10:6]);
    assign sum     = a_q + b_q;
    assign diff    = a_q - b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign instr_ready = (state_q == IDLE);
    assign done        = (state_q == WB);

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (funct)
            6'h20:   alu_res = sum;
            6'h22:   alu_res = diff;
            6'h24:   alu_res = a_q & b_q;
            6'h25:   alu_res = a_q | b_q;
            6'h26:   alu_res = a_q ^ b_q;
            6'h27:   alu_res = ~(a_q | b_q);
            6'h2A:   alu_res = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            6'h2B:   alu_res = {{(DATA_W-1){1'b0}}, a_q < b_q};
            6'h00:   alu_res = b_q << shamt_m;
            6'h02:   alu_res = b_q >> shamt_m;
            6'h03:   alu_res = $signed(b_q) >>> shamt_m;
            default: alu_ill = 1'b1;
        endcase
        if (instr_q[31:26] != 6'd0) alu_ill = 1'b1;
        if (alu_ill) alu_res = '0;
    end

`ifdef OVF_TRAP_EN
    // Signed overflow: result sign disagrees with what the operand signs force.
    logic add_ovf, sub_ovf;
    assign add_ovf = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
    assign sub_ovf = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
    assign ovf_d   = !alu_ill && (((funct == 6'h20) && add_ovf) || ((funct == 6'h22) && sub_ovf));
`else
    assign ovf_d   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q   <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            out_q     <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && instr_valid) begin
                instr_q <= instr;
                op_q    <= instr[31:26];
            end
            if (state_q == DECODE) begin
                a_q <= regs_q[rs_idx];
                b_q <= regs_q[rt_idx];
            end
            if (state_q == EXEC) begin
                out_q     <= alu_res;
                zero_q    <= (alu_res == '0);
                illegal_q <= alu_ill;
                ovf_q     <= ovf_d;
            end
        end
    end

    assign reg_we = (state_q == WB) && (rd_idx != '0) && !illegal_q && !ovf_q;

    // Register 0 resets to 0 and is never a write target, so it always reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= DATA_W'(i);
        end else if (reg_we) begin
            regs_q[rd_idx] <= out_q;
        end
    end

    assign dbg_data = regs_q[dbg_addr[IW-1:0]];
    assign out      = out_q;
    assign op       = op_q;
    assign zero     = zero_q;
    assign illegal  = illegal_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_rtype_mc_datapath.sv
// Bench for rtype_mc_datapath: directed vector table, multi-cycle corner sequences,
// and random instructions checked against an arithmetic reference model.
module tb_rtype_mc_datapath;
`ifdef OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam longint MAXS = 64'sh7FFFFFFF;
    localparam longint MINS = -64'sh80000000;

    logic        clk = 1'b0, reset = 1'b1, instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [4:0]  dbg_addr = '0;
    logic        instr_ready, zero, done, illegal, ovf;
    logic [31:0] out, dbg_data;
    logic [5:0]  op;

    rtype_mc_datapath #(.DATA_W(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .out(out), .op(op), .zero(zero), .done(done),
        .illegal(illegal), .ovf(ovf), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0;
    logic [31:0] m_regs [32];
    logic [5:0]  fl [11];

    typedef struct {
        logic [31:0] w;
        logic [31:0] out;
        logic        zero;
        logic        ill;
        logic [5:0]  op;
        logic        ovf;
        logic [4:0]  rd;
        logic [31:0] rdval;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Presents w until accepted; returns the cycle (accept edge starts cycle 1) in which done is seen.
    task automatic do_instr(input logic [31:0] w, output int lat);
        int n = 0;
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("busy_not_ready", instr_ready, 0);
        lat = 1;
        while (!done && lat < 12) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    function automatic void model(input logic [31:0] w, output logic [31:0] res,
                                  output bit ill, output bit ov);
        logic [31:0] a, b;
        longint s;
        int unsigned sh;
        a = m_regs[w[25:21]];
        b = m_regs[w[20:16]];
        sh = w[10:6];
        ill = (w[31:26] != 6'd0);
        ov = 1'b0;
        res = '0;
        case (w[5:0])
            6'h20: begin s = longint'(int'(a)) + longint'(int'(b)); res = s[31:0]; ov = (s > MAXS) || (s < MINS); end
            6'h22: begin s = longint'(int'(a)) - longint'(int'(b)); res = s[31:0]; ov = (s > MAXS) || (s < MINS); end
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h27: res = ~(a | b);
            6'h2A: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'h2B: res = (a < b) ? 32'd1 : 32'd0;
            6'h00: res = b << sh;
            6'h02: res = b >> sh;
            6'h03: res = 32'(int'(b) >>> sh);
            default: ill = 1'b1;
        endcase
        if (ill) begin res = '0; ov = 1'b0; end
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, gap, pulses, k;
        logic [31:0] v, w, eres;
        logic [5:0] f, o;
        bit eill, eov;

        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        tbl[0]  = '{32'h00221820, 32'h3,        1'b0, 1'b0, 6'h00, 1'b0, 5'd3,  32'h3};
        tbl[1]  = '{32'h00A52022, 32'h0,        1'b1, 1'b0, 6'h00, 1'b0, 5'd4,  32'h0};
        tbl[2]  = '{32'h001F3680, 32'h7C000000, 1'b0, 1'b0, 6'h00, 1'b0, 5'd6,  32'h7C000000};
        tbl[3]  = '{32'h00C63820, 32'hF8000000, 1'b0, 1'b0, 6'h00, TRAP, 5'd7,  TRAP ? 32'h7 : 32'hF8000000};
        tbl[4]  = '{32'h8C000000, 32'h0,        1'b1, 1'b1, 6'h23, 1'b0, 5'd0,  32'h0};
        tbl[5]  = '{32'h00220020, 32'h3,        1'b0, 1'b0, 6'h00, 1'b0, 5'd0,  32'h0};
        tbl[6]  = '{32'h00221821, 32'h0,        1'b1, 1'b1, 6'h00, 1'b0, 5'd3,  32'h3};
        tbl[7]  = '{32'h00E0402A, TRAP ? 32'h0 : 32'h1, TRAP, 1'b0, 6'h00, 1'b0, 5'd8, TRAP ? 32'h0 : 32'h1};
        tbl[8]  = '{32'h00005027, 32'hFFFFFFFF, 1'b0, 1'b0, 6'h00, 1'b0, 5'd10, 32'hFFFFFFFF};
        tbl[9]  = '{32'h000A5903, 32'hFFFFFFFF, 1'b0, 1'b0, 6'h00, 1'b0, 5'd11, 32'hFFFFFFFF};
        tbl[10] = '{32'h000A6702, 32'h0000000F, 1'b0, 1'b0, 6'h00, 1'b0, 5'd12, 32'h0000000F};

        // Reset state
        do_reset();
        check("rst_ready", instr_ready, 1);
        check("rst_zero", zero, 1);
        check("rst_out", out, 0);
        check("rst_op", op, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_ovf", ovf, 0);
        peek(5'd5, v);  check("rst_reg5", v, 32'd5);
        peek(5'd31, v); check("rst_reg31", v, 32'd31);
        peek(5'd0, v);  check("rst_reg0", v, 32'd0);

        // Directed vectors, applied in order from reset
        for (int i = 0; i < 11; i++) begin
            do_instr(tbl[i].w, lat);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_out", i), out, tbl[i].out);
            check($sformatf("vec%0d_zero", i), zero, tbl[i].zero);
            check($sformatf("vec%0d_illegal", i), illegal, tbl[i].ill);
            check($sformatf("vec%0d_op", i), op, tbl[i].op);
            check($sformatf("vec%0d_ovf", i), ovf, tbl[i].ovf);
            @(posedge clk); #1;
            peek(tbl[i].rd, v);
            check($sformatf("vec%0d_reg%0d", i, tbl[i].rd), v, tbl[i].rdval);
            $display("vec %0d instr=%08h out=%08h reg%0d=%08h", i, tbl[i].w, out, tbl[i].rd, v);
        end

        // instr_valid held high: second word must wait for IDLE, 4 cycles after the first
        do_reset();
        instr = 32'h00221822;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr = 32'h00A52020;
        lat = 1;
        while (!done && lat < 12) begin @(posedge clk); #1; lat++; end
        check("hold_first_latency", lat, 3);
        check("hold_first_out", out, 32'hFFFFFFFF);
        gap = 0;
        do begin @(posedge clk); #1; gap++; end while (!done && gap < 12);
        instr_valid = 1'b0;
        check("hold_gap", gap, 4);
        check("hold_second_out", out, 32'hA);
        @(posedge clk); #1;
        peek(5'd3, v); check("hold_reg3", v, 32'hFFFFFFFF);
        peek(5'd4, v); check("hold_reg4", v, 32'hA);
        $display("hold-valid sequence: gap=%0d reg3=%08h", gap, 32'hFFFFFFFF);

        // Reset during EXEC aborts the instruction
        do_reset();
        instr = 32'h00A52022;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("abort_ready", instr_ready, 1);
        check("abort_done", done, 0);
        check("abort_zero", zero, 1);
        peek(5'd4, v); check("abort_reg4_in_reset", v, 32'd4);
        @(posedge clk); #1;
        reset = 1'b0;
        pulses = 0;
        repeat (6) begin @(posedge clk); #1; if (done) pulses++; end
        check("abort_no_done", pulses, 0);
        peek(5'd4, v); check("abort_reg4", v, 32'd4);
        peek(5'd3, v); check("abort_reg3", v, 32'd3);
        $display("abort sequence: done pulses=%0d", pulses);

        // Random instructions against the reference model
        do_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
        for (int t = 0; t < 80; t++) begin
            k = $urandom_range(0, 12);
            w = $urandom;
            o = 6'd0;
            f = fl[(k < 11) ? k : 0];
            if (k == 11) o = 6'($urandom_range(1, 63));
            if (k == 12) f = 6'($urandom_range(0, 63));
            w[31:26] = o;
            w[5:0] = f;
            model(w, eres, eill, eov);
            do_instr(w, lat);
            check($sformatf("rnd%0d_latency", t), lat, 3);
            check($sformatf("rnd%0d_out", t), out, eres);
            check($sformatf("rnd%0d_zero", t), zero, eres == 32'd0);
            check($sformatf("rnd%0d_illegal", t), illegal, eill);
            check($sformatf("rnd%0d_ovf", t), ovf, TRAP && eov);
            if (!eill && w[15:11] != 5'd0 && !(TRAP && eov)) m_regs[w[15:11]] = eres;
            @(posedge clk); #1;
            peek(w[15:11], v);
            check($sformatf("rnd%0d_reg%0d", t, w[15:11]), v, m_regs[w[15:11]]);
            $display("rnd %0d instr=%08h out=%08h exp=%08h ill=%0b", t, w, out, eres, eill);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
